fetch_redirect: RTL
===================

Name: fetch_redirect

Overview:
- Fetch-stage next-PC and squash controller; consumer side of the branch-predictor interface.
- Takes the predictor's ID-stage prediction (`jump_pred`, `jump_pred_adr`) and MEM-stage recovery strobes (`jump_pred_miss`, `jump_pred_adr_miss`, `pcinc_evac`).
- Owns the PC register, issues per-stage flushes, holds redirects that arrive during an IF/ID stall, and keeps prediction statistics.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- stall  input  1  IF/ID hold (load-use hazard); PC must not advance.
- halt_id  input  1  HLT instruction decoded in ID.
- jump_pred  input  1  predictor says branch in ID is taken.
- jump_pred_adr  input  16  predicted target.
- jump_pred_miss  input  1  predicted taken, resolved not taken (MEM).
- jump_pred_adr_miss  input  1  resolved taken with a wrong or absent prediction (MEM).
- pcinc_evac  input  16  PC+1 of the mispredicted branch.
- ALUres_mem  input  16  resolved branch target (MEM).
- pc  output  16  fetch address.
- pcinc_if  output  16  pc+1, combinational, wraps modulo 2^16.
- flush_if  output  1  squash instruction in IF.
- flush_id  output  1  squash instruction in ID.
- flush_ex  output  1  squash instruction in EX.
- fetch_valid  output  1  IF holds a real instruction.
- pred_hit_cnt  output  CNT_W  predictions not followed by recovery.
- pred_miss_cnt  output  CNT_W  recovery events.

Behaviour:
- Reset (async, any state, including mid-pending):
  - pc=RESET_PC; state=RUN; pending cleared; counters 0.
  - All flushes 0; fetch_valid=0 for the first cycle after reset deasserts, then 1.
- States: RUN, PEND, HALT.
- Next-PC priority, evaluated every cycle:
  1. Recovery (MEM) — highest priority.
     - jump_pred_miss: target=pcinc_evac.
     - jump_pred_adr_miss: target=ALUres_mem.
     - Both set at once is illegal; assert in simulation; adr_miss wins.
     - Applies even when stall=1 and from any state, including HALT, since a wrong-path HLT may be squashed.
     - pc<=target next edge; flush_if=flush_id=flush_ex=1 in the same cycle.
     - Clears any PEND entry; state<=RUN; pred_miss_cnt++.
  2. Prediction (ID).
     - If jump_pred and stall=0: pc<=jump_pred_adr; flush_if=1 (sequential fetch is wrong-path).
     - If jump_pred and stall=1: latch jump_pred_adr into pending_target; state<=PEND; pc holds; no flush.
  3. PEND and stall=0: pc<=pending_target; flush_if=1; state<=RUN.
     - PEND and stall=1: hold.
     - New jump_pred while in PEND is ignored; the predictor is busy for two cycles, so this cannot legally occur.
  4. RUN, stall=0: pc<=pcinc_if. Stall=1: pc holds.
- halt_id with stall=0 and no recovery: state<=HALT; pc holds; fetch_valid=0.
  - Only recovery or reset leaves HALT.
- pred_hit_cnt increments two cycles after an accepted prediction (the cycle the branch is in MEM) when no recovery strobe is seen that cycle.
  - Tracked with a 2-bit shift register; recovery clears it.
- Counters saturate at all-ones; no wrap.
- pc wrap: 16'hFFFF+1 -> 16'h0000.

Decomposition:
- Shared package (pipeline_pkg):
  - state enum {RUN, PEND, HALT};
  - constant RESET_PC_DEFAULT;
  - typedef word_t = logic [15:0].
- One sub-module: sat_counter (CNT_W wide, inc, saturating, async reset), instantiated twice.

Test Plan:
- Reset mid-PEND at pc=16'h0040 -> pc=16'h0000, state RUN, counters 0, flushes 0 immediately (async).
- Sequential fetch from 0, no events, 5 cycles -> pc 0,1,2,3,4; flushes never asserted.
- jump_pred=1, jump_pred_adr=16'h0100 at pc=16'h0010, stall=0 -> next pc=16'h0100, flush_if=1 for one cycle; no recovery 2 cycles later -> pred_hit_cnt=1.
- jump_pred with stall=1 for 3 cycles, target 16'h0200 -> pc holds 3 cycles, then 16'h0200 with flush_if=1 on the release cycle.
- jump_pred_miss, pcinc_evac=16'h0011 -> next pc=16'h0011, flush_if/id/ex=1, pred_miss_cnt=1, no hit counted.
- jump_pred_adr_miss, ALUres_mem=16'h0300 while in HALT and stall=1 -> pc=16'h0300, state RUN, fetch_valid=1.
- Preload pred_miss_cnt to all-ones, then one more recovery -> count stays all-ones.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the fetch redirect slice.
package pipeline_pkg;

   typedef logic [15:0] word_t;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      PEND = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam word_t RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != '1))
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_redirect.sv
// Fetch next-PC selection, squash generation and prediction statistics.
module fetch_redirect
   import pipeline_pkg::*;
#(
   parameter word_t RESET_PC = RESET_PC_DEFAULT,
   parameter int    CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             halt_id,
   input  logic             jump_pred,
   input  word_t            jump_pred_adr,
   input  logic             jump_pred_miss,
   input  logic             jump_pred_adr_miss,
   input  word_t            pcinc_evac,
   input  word_t            ALUres_mem,
   output word_t            pc,
   output word_t            pcinc_if,
   output logic             flush_if,
   output logic             flush_id,
   output logic             flush_ex,
   output logic             fetch_valid,
   output logic [CNT_W-1:0] pred_hit_cnt,
   output logic [CNT_W-1:0] pred_miss_cnt
);

   state_t     r_state;
   state_t     w_state_nxt;
   word_t      r_pc;
   word_t      w_pc_nxt;
   word_t      r_pend_tgt;
   logic       w_pend_ld;
   logic       w_accept;
   logic       w_rec;
   word_t      w_rec_tgt;
   logic       r_init;
   logic [1:0] r_hit_sr;
   logic       w_hit_inc;

   assign w_rec     = jump_pred_miss | jump_pred_adr_miss;
   assign w_rec_tgt = jump_pred_adr_miss ? ALUres_mem : pcinc_evac;
   assign pcinc_if  = r_pc + 16'd1;
   assign pc        = r_pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= RUN;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_pend_ld   = 1'b0;
      w_accept    = 1'b0;
      if (w_rec) begin
         w_state_nxt = RUN;
         w_pc_nxt    = w_rec_tgt;
      end else begin
         unique case (r_state)
            RUN: begin
               if (jump_pred && !stall) begin
                  w_pc_nxt = jump_pred_adr;
                  w_accept = 1'b1;
               end else if (jump_pred) begin
                  w_state_nxt = PEND;
                  w_pend_ld   = 1'b1;
               end else if (halt_id && !stall) begin
                  w_state_nxt = HALT;
               end else if (!stall) begin
                  w_pc_nxt = pcinc_if;
               end
            end
            PEND: begin
               if (!stall) begin
                  w_pc_nxt    = r_pend_tgt;
                  w_state_nxt = RUN;
                  w_accept    = 1'b1;
               end
            end
            HALT: begin
               w_state_nxt = HALT;
            end
            default: begin
               w_state_nxt = RUN;
            end
         endcase
      end
   end

   always_comb begin
      flush_if    = !reset && (w_rec || w_accept);
      flush_id    = !reset && w_rec;
      flush_ex    = !reset && w_rec;
      fetch_valid = r_init && (r_state != HALT);
   end

   // Hit is credited when an accepted prediction reaches MEM unchallenged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc       <= RESET_PC;
         r_pend_tgt <= '0;
         r_init     <= 1'b0;
         r_hit_sr   <= 2'b00;
      end else begin
         r_pc   <= w_pc_nxt;
         r_init <= 1'b1;
         if (w_pend_ld)
            r_pend_tgt <= jump_pred_adr;
         if (w_rec)
            r_hit_sr <= 2'b00;
         else
            r_hit_sr <= {r_hit_sr[0], w_accept};
      end
   end

   assign w_hit_inc = r_hit_sr[1] && !w_rec;

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset)
         assert (!(jump_pred_miss && jump_pred_adr_miss))
            else $error("both recovery strobes set");
   end
`endif

   sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_hit_inc),
      .o_cnt (pred_hit_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .reset (reset),
      .i_inc (w_rec),
      .o_cnt (pred_miss_cnt)
   );

endmodule
